// File: rtl/ao_pkg.sv
// Shared definitions for the AND-OR expander family.
package ao_pkg;

    localparam int unsigned AO_NUM_TERMS  = 3;
    localparam int unsigned AO_TERM_WIDTH = 3;

    // Input bits of one product term.
    typedef logic [AO_TERM_WIDTH-1:0] ao_term_t;

    // Input bits of every product term, term 0 at index 0.
    typedef ao_term_t [AO_NUM_TERMS-1:0] ao_terms_t;

endpackage : ao_pkg

// File: rtl/ao_and3_term.sv
// Single 3-input product term (combinational AND of its inputs).
module ao_and3_term
    import ao_pkg::*;
(
    input  ao_term_t i_in,
    output logic     o_prod_c
);

    // Reduction AND so a 0 on any input forces the term low even when
    // another input is X/Z.
    assign o_prod_c = &i_in;

endmodule : ao_and3_term

// File: rtl/ao_exp_1.sv
// 9-input AND-OR expander: Y = (A&B&C) | (D&E&F) | (G&H&I), registered once.
module ao_exp_1
    import ao_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    input  logic E,
    input  logic F,
    input  logic G,
    input  logic H,
    input  logic I,
    output logic Y
);

    ao_terms_t                 w_term_in;
    logic [AO_NUM_TERMS-1:0]   w_prod;
    logic                      w_y_next;
    logic                      r_y;

    // Group the flat inputs into their product terms.
    assign w_term_in[0] = {A, B, C};
    assign w_term_in[1] = {D, E, F};
    assign w_term_in[2] = {G, H, I};

    // One AND term per input group.
    for (genvar g = 0; g < int'(AO_NUM_TERMS); g++) begin : g_term
        ao_and3_term u_term (
            .i_in     (w_term_in[g]),
            .o_prod_c (w_prod[g])
        );
    end

    // Reduction OR keeps a true term dominant over X on the others.
    assign w_y_next = |w_prod;

    // Output register with synchronous reset taking priority over the terms.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= RST_VAL;
        end else begin
            r_y <= w_y_next;
        end
    end

    assign Y = r_y;

endmodule : ao_exp_1

// File: tb/tb_ao_exp_1.sv
// Self-checking bench for the AND-OR expander.
module tb_ao_exp_1;

    logic clk;
    logic rst;
    logic A, B, C, D, E, F, G, H, I;
    logic Y;

    int n_checks;
    int n_fail;

    ao_exp_1 #(.RST_VAL(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .C   (C),
        .D   (D),
        .E   (E),
        .F   (F),
        .G   (G),
        .H   (H),
        .I   (I),
        .Y   (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: output is 1 when any group of three consecutive inputs is all ones.
    function automatic logic model_y(input logic [8:0] v);
        return ($countones(v[8:6]) == 3) || ($countones(v[5:3]) == 3) ||
               ($countones(v[2:0]) == 3);
    endfunction

    // Bit 8 is A, bit 0 is I.
    task automatic drive(input logic [8:0] v, input logic r);
        {A, B, C, D, E, F, G, H, I} = v;
        rst = r;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick();
        drive(9'b0, 1'b1);
        tick();
        tick();
        n_checks++;
        if (Y !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: Y=%b expected 0", Y);
        end
        drive(9'b000111000, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (Y !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold_def cycle %0d: Y=%b expected 0", k, Y);
            end
        end
    endtask

    task automatic test_term1();
        logic [8:0] v;
        v = 9'b001111010;
        drive(v, 1'b0);
        // Before the capturing edge the output still shows the reset value.
        #1;
        n_checks++;
        if (Y !== 1'b0) begin
            n_fail++;
            $display("FAIL term1_latency: Y=%b expected 0 before edge", Y);
        end
        tick();
        n_checks++;
        if (Y !== model_y(v)) begin
            n_fail++;
            $display("FAIL term1_only: Y=%b expected %b", Y, model_y(v));
        end
    endtask

    task automatic test_each_term();
        logic [8:0] v;
        logic [8:0] vc;
        for (int t = 0; t < 3; t++) begin
            v = 9'b111 << (6 - 3 * t);
            drive(v, 1'b0);
            tick();
            n_checks++;
            if (Y !== model_y(v)) begin
                n_fail++;
                $display("FAIL term%0d_alone: Y=%b expected %b", t, Y, model_y(v));
            end
            for (int b = 0; b < 3; b++) begin
                vc = v;
                vc[6 - 3 * t + b] = 1'b0;
                drive(vc, 1'b0);
                tick();
                n_checks++;
                if (Y !== model_y(vc)) begin
                    n_fail++;
                    $display("FAIL term%0d_clear_bit%0d: Y=%b expected %b", t, b, Y,
                             model_y(vc));
                end
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [8:0] v;
        int         errs;
        errs = 0;
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            drive(v, 1'b0);
            tick();
            n_checks++;
            if (Y !== model_y(v)) begin
                n_fail++;
                errs++;
                if (errs <= 8)
                    $display("FAIL exhaustive vec=%b: Y=%b expected %b", v, Y, model_y(v));
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] v;
        logic       r;
        logic       exp_y;
        for (int i = 0; i < 200; i++) begin
            v = 9'($urandom);
            r = ($urandom_range(0, 9) == 0);
            drive(v, r);
            exp_y = r ? 1'b0 : model_y(v);
            tick();
            n_checks++;
            if (Y !== exp_y) begin
                n_fail++;
                $display("FAIL random vec=%b rst=%b: Y=%b expected %b", v, r, Y, exp_y);
            end
        end
    endtask

    task automatic test_x_dominance();
        // True term wins over X elsewhere.
        drive(9'b001111000, 1'b0);
        A = 1'bx;
        tick();
        n_checks++;
        if (Y !== 1'b1) begin
            n_fail++;
            $display("FAIL x_true_term: Y=%b expected 1", Y);
        end
        // Zero in the same term masks X; no other term true.
        drive(9'b001000000, 1'b0);
        A = 1'bx;
        tick();
        n_checks++;
        if (Y !== 1'b0) begin
            n_fail++;
            $display("FAIL x_zero_mask: Y=%b expected 0", Y);
        end
    endtask

    task automatic test_reset_mid();
        drive(9'b111000000, 1'b0);
        tick();
        n_checks++;
        if (Y !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: Y=%b expected 1", Y);
        end
        drive(9'b111000000, 1'b1);
        tick();
        n_checks++;
        if (Y !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst: Y=%b expected 0", Y);
        end
        drive(9'b111000000, 1'b0);
        tick();
        n_checks++;
        if (Y !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_release: Y=%b expected 1", Y);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive(9'b0, 1'b1);
        test_reset();
        test_term1();
        test_each_term();
        test_exhaustive();
        test_random();
        test_x_dominance();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ao_exp_1
